// File: rtl/loader_frame_sequencer_pkg.sv
// Shared types and helpers for the configuration frame sequencer and its SELECT pulse generator.
package loader_frame_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_LEN    = 3'd2,
    ST_DATA   = 3'd3,
    ST_STROBE = 3'd4,
    ST_GAP    = 3'd5,
    ST_FIN    = 3'd6,
    ST_ERR    = 3'd7
  } seq_state_e;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_HIGH = 2'd1,
    PH_LOW  = 2'd2
  } pulse_phase_e;

  // A length word of zero terminates the bitstream.
  localparam int LEN_EOB = 0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/loader_frame_sequencer_select_pulse_gen.sv
// SELECT shaper: a trigger produces STROBE_CYCLES high followed by GAP_CYCLES low, then pulse_done.
module loader_frame_sequencer_select_pulse_gen
  import loader_frame_sequencer_pkg::*;
#(
  parameter int STROBE_CYCLES = 1,
  parameter int GAP_CYCLES    = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic trigger,
  output logic select,
  output logic strobe_last,
  output logic pulse_done
);

  localparam int CW = $clog2(max_int(STROBE_CYCLES, GAP_CYCLES) + 1);

  pulse_phase_e    phase_q, phase_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      phase_q <= PH_IDLE;
      cnt_q   <= '0;
      select  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      select  <= (phase_d == PH_HIGH);
    end
  end

  always_comb begin
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    strobe_last = (phase_q == PH_HIGH) && (cnt_q == '0);
    pulse_done  = (phase_q == PH_LOW) && (cnt_q == '0);
    case (phase_q)
      PH_IDLE: begin
        if (trigger) begin
          phase_d = PH_HIGH;
          cnt_d   = CW'(STROBE_CYCLES - 1);
        end
      end
      PH_HIGH: begin
        if (cnt_q == '0) begin
          phase_d = PH_LOW;
          cnt_d   = CW'(GAP_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      PH_LOW: begin
        if (cnt_q == '0) phase_d = PH_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: begin
        phase_d = PH_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/loader_frame_sequencer.sv
// Parses the byte-stream configuration bitstream into frames and drives ADDRESS/DATA/SELECT
// to the switch-block loader tree, one SELECT pulse per payload word.
//
// state  | meaning
// IDLE   | waiting for START
// ADDR   | collecting HDR_WORDS address words, MSB-first
// LEN    | reading frame length; zero ends the bitstream
// DATA   | waiting for the next payload word
// STROBE | SELECT high
// GAP    | SELECT low; decides next word, next frame or overflow
// FIN    | end of bitstream: raise DONE
// ERR    | address overflow inside a frame: raise ERROR
module loader_frame_sequencer
  import loader_frame_sequencer_pkg::*;
#(
  parameter int ADDRESS_SIZE  = 9,
  parameter int DATA_SIZE     = 8,
  parameter int STROBE_CYCLES = 1,
  parameter int GAP_CYCLES    = 2
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    START,
  input  logic                    IN_VALID,
  input  logic [DATA_SIZE-1:0]    IN_DATA,
  output logic                    IN_READY,
  output logic [ADDRESS_SIZE-1:0] ADDRESS,
  output logic [DATA_SIZE-1:0]    DATA,
  output logic                    SELECT,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    ERROR
);

  localparam int HDR_WORDS = ceil_div(ADDRESS_SIZE, DATA_SIZE);
  localparam int SH_W      = HDR_WORDS * DATA_SIZE;
  localparam int IDX_W     = $clog2(HDR_WORDS + 1);

  seq_state_e              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [SH_W-1:0]         addr_sh_q, addr_sh_d;
  logic [DATA_SIZE-1:0]    rem_q, rem_d;
  logic [ADDRESS_SIZE-1:0] address_q, address_d;
  logic [DATA_SIZE-1:0]    data_q, data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic                    in_ready_q, in_ready_d;

  logic xfer;
  logic pulse_trigger;
  logic strobe_last;
  logic pulse_done;

  assign xfer          = IN_VALID && in_ready_q;
  assign pulse_trigger = (state_q == ST_DATA) && xfer;

  loader_frame_sequencer_select_pulse_gen #(
    .STROBE_CYCLES (STROBE_CYCLES),
    .GAP_CYCLES    (GAP_CYCLES)
  ) u_pulse (
    .CLK         (CLK),
    .RESET       (RESET),
    .trigger     (pulse_trigger),
    .select      (SELECT),
    .strobe_last (strobe_last),
    .pulse_done  (pulse_done)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      addr_sh_q  <= '0;
      rem_q      <= '0;
      address_q  <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      addr_sh_q  <= addr_sh_d;
      rem_q      <= rem_d;
      address_q  <= address_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    addr_sh_d = addr_sh_q;
    rem_d     = rem_q;
    address_d = address_q;
    data_d    = data_q;
    busy_d    = busy_q;
    done_d    = done_q;
    error_d   = error_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d   = ST_ADDR;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          error_d   = 1'b0;
          idx_d     = '0;
          addr_sh_d = '0;
        end
      end
      ST_ADDR: begin
        if (xfer) begin
          // Upper bits beyond ADDRESS_SIZE shift in but are never used.
          addr_sh_d = (addr_sh_q << DATA_SIZE) | SH_W'(IN_DATA);
          if (idx_q == IDX_W'(HDR_WORDS - 1)) begin
            idx_d   = '0;
            state_d = ST_LEN;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_LEN: begin
        if (xfer) begin
          if (IN_DATA == DATA_SIZE'(LEN_EOB)) begin
            state_d = ST_FIN;
          end else begin
            rem_d     = IN_DATA;
            address_d = addr_sh_q[ADDRESS_SIZE-1:0];
            state_d   = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (xfer) begin
          data_d  = IN_DATA;
          state_d = ST_STROBE;
        end
      end
      ST_STROBE: begin
        if (strobe_last) begin
          rem_d   = rem_q - DATA_SIZE'(1);
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (pulse_done) begin
          if (rem_q == '0) begin
            idx_d     = '0;
            addr_sh_d = '0;
            state_d   = ST_ADDR;
          end else if (&address_q) begin
            // No wrap: another word past the top address is an overflow.
            state_d = ST_ERR;
          end else begin
            address_d = address_q + ADDRESS_SIZE'(1);
            state_d   = ST_DATA;
          end
        end
      end
      ST_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        error_d = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d = (state_d == ST_ADDR) || (state_d == ST_LEN) || (state_d == ST_DATA);
  end

  assign IN_READY = in_ready_q;
  assign ADDRESS  = address_q;
  assign DATA     = data_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign ERROR    = error_q;

endmodule

// File: tb/tb_loader_frame_sequencer.sv
// Bench for loader_frame_sequencer: table of bitstreams with expected pulses, scoreboard on SELECT.
module tb_loader_frame_sequencer;

  localparam int STROBE = 1;

  logic       CLK;
  logic       RESET;
  logic       START;
  logic       IN_VALID;
  logic [7:0] IN_DATA;
  logic       IN_READY;
  logic [8:0] ADDRESS;
  logic [7:0] DATA;
  logic       SELECT;
  logic       BUSY;
  logic       DONE;
  logic       ERROR;

  loader_frame_sequencer #(
    .ADDRESS_SIZE  (9),
    .DATA_SIZE     (8),
    .STROBE_CYCLES (STROBE),
    .GAP_CYCLES    (2)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .START    (START),
    .IN_VALID (IN_VALID),
    .IN_DATA  (IN_DATA),
    .IN_READY (IN_READY),
    .ADDRESS  (ADDRESS),
    .DATA     (DATA),
    .SELECT   (SELECT),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .ERROR    (ERROR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [8:0] a;
    logic [7:0] d;
  } exp_t;

  // words and pulses are packed first-item-leftmost; pulse entries are {addr[8:0], data[7:0]}
  typedef struct {
    string       name;
    int          nw;
    logic [95:0] words;
    int          np;
    logic [67:0] pulses;
    bit          bp;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  vec_t vecs[6];
  exp_t sbq[$];

  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  logic       prev_sel = 1'b0;
  int         hi       = 0;
  logic [8:0] cur_a;
  logic [7:0] cur_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One cycle: wait for the falling edge, then observe SELECT pulses against the scoreboard.
  task automatic tick();
    exp_t e;
    @(negedge CLK);
    cyc++;
    if (SELECT && !prev_sel) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse actual_addr=%0h actual_data=%0h required=none", ADDRESS, DATA);
      end else begin
        e = sbq.pop_front();
        check("pulse_addr", 32'(ADDRESS), 32'(e.a));
        check("pulse_data", 32'(DATA), 32'(e.d));
      end
      cur_a = ADDRESS;
      cur_d = DATA;
      hi    = 0;
    end
    if (SELECT) begin
      hi++;
      check("ready_low_in_pulse", 32'(IN_READY), 32'd0);
    end
    if (!SELECT && prev_sel && RESET) begin
      check("pulse_width", 32'(hi), 32'(STROBE));
      check("addr_stable", 32'(ADDRESS), 32'(cur_a));
      check("data_stable", 32'(DATA), 32'(cur_d));
    end
    prev_sel = SELECT;
  endtask

  task automatic start_frame();
    tick();
    START = 1'b1;
    tick();
    START = 1'b0;
    check("busy_after_start", 32'(BUSY), 32'd1);
    check("done_clear_after_start", 32'(DONE), 32'd0);
  endtask

  task automatic feed_word(input logic [7:0] w, input bit bp, output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 80; n++) begin
      tick();
      if (!BUSY) begin
        IN_VALID = 1'b0;
        return;
      end
      IN_VALID = bp ? cyc[0] : 1'b1;
      IN_DATA  = IN_VALID ? w : 8'hEE;
      if (IN_VALID && IN_READY) begin
        ok = 1'b1;
        return;
      end
    end
    IN_VALID = 1'b0;
    check("feed_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_idle();
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      tick();
      IN_VALID = 1'b0;
      if (!BUSY) seen = 1'b1;
    end
    check("idle_reached", 32'(seen), 32'd1);
    for (int n = 0; n < 8; n++) tick();
  endtask

  task automatic run_vec(input vec_t v);
    logic [16:0] e;
    logic        ok;
    for (int k = 0; k < v.np; k++) begin
      e = v.pulses[(v.np-1-k)*17 +: 17];
      sbq.push_back('{e[16:8], e[7:0]});
    end
    start_frame();
    for (int k = 0; k < v.nw; k++) begin
      feed_word(v.words[(v.nw-1-k)*8 +: 8], v.bp, ok);
      if (!ok) break;
    end
    wait_idle();
    check({v.name, "_done"}, 32'(DONE), 32'(v.exp_done));
    check({v.name, "_error"}, 32'(ERROR), 32'(v.exp_err));
    check({v.name, "_busy"}, 32'(BUSY), 32'd0);
    check({v.name, "_pulses_left"}, 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  initial begin
    logic ok;
    logic seen;

    vecs[0] = '{"single", 9, 96'h01_2A_03_AA_BB_CC_00_00_00, 3,
                68'({9'h12A, 8'hAA, 9'h12B, 8'hBB, 9'h12C, 8'hCC}), 1'b0, 1'b1, 1'b0};
    vecs[1] = '{"backpressure", 9, 96'h01_2A_03_AA_BB_CC_00_00_00, 3,
                68'({9'h12A, 8'hAA, 9'h12B, 8'hBB, 9'h12C, 8'hCC}), 1'b1, 1'b1, 1'b0};
    vecs[2] = '{"overflow", 5, 96'h01_FF_02_11_22, 1,
                68'({9'h1FF, 8'h11}), 1'b0, 1'b0, 1'b1};
    vecs[3] = '{"edge_legal", 7, 96'h01_FF_01_33_00_00_00, 1,
                68'({9'h1FF, 8'h33}), 1'b0, 1'b1, 1'b0};
    vecs[4] = '{"upper_bits", 7, 96'hFE_05_01_77_00_00_00, 1,
                68'({9'h005, 8'h77}), 1'b0, 1'b1, 1'b0};
    vecs[5] = '{"multi_frame", 12, 96'h00_00_01_5A_01_00_02_C3_3C_00_00_00, 3,
                68'({9'h000, 8'h5A, 9'h100, 8'hC3, 9'h101, 8'h3C}), 1'b0, 1'b1, 1'b0};

    RESET    = 1'b0;
    START    = 1'b0;
    IN_VALID = 1'b0;
    IN_DATA  = 8'h00;
    tick();
    tick();
    RESET = 1'b1;
    tick();
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_error", 32'(ERROR), 32'd0);
    check("rst_select", 32'(SELECT), 32'd0);
    check("rst_ready", 32'(IN_READY), 32'd0);
    check("rst_address", 32'(ADDRESS), 32'd0);

    // Reset in the middle of a SELECT pulse
    sbq.push_back('{9'h12A, 8'hAA});
    start_frame();
    feed_word(8'h01, 1'b0, ok);
    feed_word(8'h2A, 1'b0, ok);
    feed_word(8'h03, 1'b0, ok);
    feed_word(8'hAA, 1'b0, ok);
    tick();
    IN_VALID = 1'b0;
    check("mid_pulse_select_high", 32'(SELECT), 32'd1);
    #2 RESET = 1'b0;
    #1;
    check("async_rst_select", 32'(SELECT), 32'd0);
    check("async_rst_busy", 32'(BUSY), 32'd0);
    check("async_rst_ready", 32'(IN_READY), 32'd0);
    check("async_rst_data", 32'(DATA), 32'd0);
    tick();
    RESET = 1'b1;
    tick();
    tick();
    check("post_rst_ready", 32'(IN_READY), 32'd0);
    check("post_rst_busy", 32'(BUSY), 32'd0);
    check("post_rst_pulses_left", 32'(sbq.size()), 32'd0);
    sbq.delete();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // START held high across end of bitstream restarts the parser
    tick();
    START = 1'b1;
    tick();
    check("restart_done_cleared", 32'(DONE), 32'd0);
    check("restart_busy", 32'(BUSY), 32'd1);
    for (int k = 0; k < 3; k++) feed_word(8'h00, 1'b0, ok);
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      tick();
      IN_VALID = 1'b0;
      if (DONE) seen = 1'b1;
    end
    check("held_start_done_seen", 32'(seen), 32'd1);
    check("held_start_busy_low", 32'(BUSY), 32'd0);
    tick();
    check("auto_restart_done", 32'(DONE), 32'd0);
    check("auto_restart_busy", 32'(BUSY), 32'd1);
    check("auto_restart_ready", 32'(IN_READY), 32'd1);
    START = 1'b0;
    for (int k = 0; k < 3; k++) feed_word(8'h00, 1'b0, ok);
    wait_idle();
    check("auto_restart_final_done", 32'(DONE), 32'd1);
    check("auto_restart_final_error", 32'(ERROR), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
